// File: rtl/mux_rr_sched.sv
// mux_rr_sched: four-lane round-robin scheduler with a 2-entry FIFO per lane
// and a registered output stage. Each output word is tagged with its source lane.
//
// Handshake: a lane word transfers on the rising aclk edge where valid_i and
// ready_i are both 1. An output word transfers on the edge where valid_out and
// out_ready are both 1. While valid_out = 1 and out_ready = 0, valid_out,
// data_out and lane_out hold stable. ready_i depends only on the registered
// FIFO count and on reset. It never depends combinationally on out_ready or
// lane_en.
module mux_rr_sched #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  aclk,
    input  logic                  reset,
    input  logic                  valid0,
    input  logic                  valid1,
    input  logic                  valid2,
    input  logic                  valid3,
    input  logic [DATA_WIDTH-1:0] data_in0,
    input  logic [DATA_WIDTH-1:0] data_in1,
    input  logic [DATA_WIDTH-1:0] data_in2,
    input  logic [DATA_WIDTH-1:0] data_in3,
    output logic                  ready0,
    output logic                  ready1,
    output logic                  ready2,
    output logic                  ready3,
    input  logic [3:0]            lane_en,
    input  logic                  out_ready,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [1:0]            lane_out
);

    // The count register is 2 bits wide, so full means count == 2.
    localparam logic [1:0] FULL = 2'(FIFO_DEPTH);

    logic [3:0]                 valid_in;
    logic [3:0][DATA_WIDTH-1:0] din;
    logic [3:0][DATA_WIDTH-1:0] head;
    logic [3:0][1:0]            cnt;
    logic [3:0]                 ready_int;
    logic [3:0]                 push;
    logic [3:0]                 pop;
    logic [3:0]                 eligible;
    logic [1:0]                 rr;
    logic [1:0]                 grant;
    logic [1:0]                 idx;
    logic                       grant_found;
    logic                       load;

    assign valid_in = {valid3, valid2, valid1, valid0};
    assign din      = {data_in3, data_in2, data_in1, data_in0};
    assign ready0   = ready_int[0];
    assign ready1   = ready_int[1];
    assign ready2   = ready_int[2];
    assign ready3   = ready_int[3];
    assign push     = valid_in & ready_int;
    assign load     = ~valid_out | out_ready;

    // Lane readiness and eligibility come from the registered counts only.
    always_comb begin
        ready_int = '0;
        eligible  = '0;
        for (int i = 0; i < 4; i++) begin
            ready_int[i] = ~reset && (cnt[i] != FULL);
            eligible[i]  = (cnt[i] != 2'd0) && lane_en[i];
        end
    end

    // Pick the first eligible lane in the order rr, rr+1, rr+2, rr+3.
    always_comb begin
        grant_found = 1'b0;
        grant       = rr;
        idx         = '0;
        for (int k = 0; k < 4; k++) begin
            idx = rr + 2'(k);
            if (!grant_found && eligible[idx]) begin
                grant_found = 1'b1;
                grant       = idx;
            end
        end
    end

    // Pop only the granted lane, and only when the output register loads.
    always_comb begin
        pop = '0;
        if (load && grant_found) begin
            pop[grant] = 1'b1;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [DATA_WIDTH-1:0] mem [2];
        logic [1:0]            count_q;
        logic                  wr_ptr;
        logic                  rd_ptr;

        // Pointer and occupancy bookkeeping. A push and a pop in the same cycle
        // leave the count unchanged.
        always_ff @(posedge aclk or posedge reset) begin
            if (reset) begin
                count_q <= 2'd0;
                wr_ptr  <= 1'b0;
                rd_ptr  <= 1'b0;
            end else begin
                if (push[i]) wr_ptr <= ~wr_ptr;
                if (pop[i])  rd_ptr <= ~rd_ptr;
                case ({push[i], pop[i]})
                    2'b10:   count_q <= count_q + 2'd1;
                    2'b01:   count_q <= count_q - 2'd1;
                    default: count_q <= count_q;
                endcase
            end
        end

        // Storage needs no reset: the count gates every read.
        always_ff @(posedge aclk) begin
            if (push[i]) mem[wr_ptr] <= din[i];
        end

        assign cnt[i]  = count_q;
        assign head[i] = mem[rd_ptr];
    end

    // Output register and rr pointer. Both hold under back-pressure, and both
    // clear on reset so no pending word survives.
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            valid_out <= 1'b0;
            data_out  <= '0;
            lane_out  <= 2'd0;
            rr        <= 2'd0;
        end else if (load) begin
            if (grant_found) begin
                valid_out <= 1'b1;
                data_out  <= head[grant];
                lane_out  <= grant;
                rr        <= grant + 2'd1;
            end else begin
                valid_out <= 1'b0;
            end
        end
    end

endmodule
